// File: rtl/ped_cond_pkg.sv
// Shared types and constants for the pedestrian request conditioner.
// The debounce state encoding and the press-counter width live here.
package ped_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW    = 2'd0,
    DEBOUNCE_HIGH = 2'd1,
    STABLE_HIGH   = 2'd2,
    DEBOUNCE_LOW  = 2'd3
  } db_state_t;

  localparam int COUNT_W = 8;

  // The debounced level is high while the button is accepted as pressed,
  // including while a release is still being qualified.
  function automatic logic level_of(input db_state_t s);
    return (s == STABLE_HIGH) || (s == DEBOUNCE_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops clear immediately on rst.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ped_request_conditioner.sv
// Debounces the pedestrian push-button and turns each press into a latched
// request for the traffic-light controller, plus a saturating press count.
module ped_request_conditioner
  import ped_cond_pkg::*;
#(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  input  logic               ack,
  output logic               btn_level,
  output logic               btn_pulse,
  output logic               req_pending,
  output logic [COUNT_W-1:0] req_count
);

  localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int CNT_W     = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  // The state flips on the sample that brings the count to DB_CYCLES-1,
  // i.e. when the register still holds DB_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  generate
    if (DB_CYCLES < 2) begin : g_bad_cfg
      $error("ped_request_conditioner: DB_CYCLES must be at least 2");
    end
  endgenerate

  logic btn_sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  db_state_t          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               level_reg, level_next;
  logic               pulse_reg, pulse_next;
  logic               pending_reg, pending_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= STABLE_LOW;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      pulse_reg   <= 1'b0;
      pending_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      pulse_reg   <= pulse_next;
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      STABLE_LOW: begin
        if (btn_sync) begin
          state_next = DEBOUNCE_HIGH;
          cnt_next   = '0;
        end
      end
      DEBOUNCE_HIGH: begin
        if (!btn_sync) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!btn_sync) begin
          state_next = DEBOUNCE_LOW;
          cnt_next   = '0;
        end
      end
      DEBOUNCE_LOW: begin
        if (btn_sync) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = STABLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Level and pulse are registered from the next state so they track the FSM
  // without an extra cycle of delay.
  always_comb begin
    level_next = level_of(state_next);
    pulse_next = level_next && !level_reg;
  end

  // A fresh press outranks a simultaneous ack so no request is lost.
  always_comb begin
    pending_next = pending_reg;
    if (pulse_reg) begin
      pending_next = 1'b1;
    end else if (ack) begin
      pending_next = 1'b0;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (pulse_reg && (count_reg != COUNT_MAX)) begin
      count_next = count_reg + COUNT_W'(1);
    end
  end

  assign btn_level   = level_reg;
  assign btn_pulse   = pulse_reg;
  assign req_pending = pending_reg;
  assign req_count   = count_reg;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Directed bench for ped_request_conditioner with DB_CYCLES = 4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_ped_request_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       ack;
  logic       btn_level;
  logic       btn_pulse;
  logic       req_pending;
  logic [7:0] req_count;

  int n_checks;
  int n_pass;
  int pulse_seen;

  ped_request_conditioner #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .ack         (ack),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .req_pending (req_pending),
    .req_count   (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
      $display("ok   %s = %0d", tag, actual);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (btn_pulse === 1'b1) pulse_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    pulse_seen = 0;
    rst        = 1'b1;
    btn_raw    = 1'b0;
    ack        = 1'b0;
    ticks(2);
    check("rst_level",   32'(btn_level),   0);
    check("rst_pulse",   32'(btn_pulse),   0);
    check("rst_pending", 32'(req_pending), 0);
    check("rst_count",   32'(req_count),   0);
    rst = 1'b0;
    ticks(2);

    // Glitch of 3 cycles must be rejected
    pulse_seen = 0;
    btn_raw = 1'b1;
    ticks(3);
    btn_raw = 1'b0;
    ticks(10);
    check("glitch_level",   32'(btn_level),   0);
    check("glitch_pulses",  32'(pulse_seen),  0);
    check("glitch_pending", 32'(req_pending), 0);
    check("glitch_count",   32'(req_count),   0);

    // Clean press held 20 cycles: level rises on 6th edge
    pulse_seen = 0;
    btn_raw = 1'b1;
    ticks(5);
    check("press_level_e5", 32'(btn_level), 0);
    tick();
    check("press_level_e6", 32'(btn_level), 1);
    check("press_pulse_e6", 32'(btn_pulse), 1);
    check("press_pend_e6",  32'(req_pending), 0);
    tick();
    check("press_pulse_e7", 32'(btn_pulse),   0);
    check("press_pend_e7",  32'(req_pending), 1);
    check("press_count_e7", 32'(req_count),   1);
    ticks(13);
    check("hold_pulses", 32'(pulse_seen), 1);
    check("hold_level",  32'(btn_level),  1);
    btn_raw = 1'b0;
    ticks(5);
    check("release_level_e5", 32'(btn_level), 1);
    tick();
    check("release_level_e6", 32'(btn_level), 0);
    ticks(2);
    check("release_pulses",  32'(pulse_seen),  1);
    check("release_pending", 32'(req_pending), 1);

    // Ack clears pending; ack with nothing pending does nothing
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_clear", 32'(req_pending), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("ack_idle_pending", 32'(req_pending), 0);
    check("ack_idle_count",   32'(req_count),   1);

    // Pulse coincident with ack: request wins
    btn_raw = 1'b1;
    ticks(6);
    check("coinc_pulse", 32'(btn_pulse), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("coinc_pending", 32'(req_pending), 1);
    check("coinc_count",   32'(req_count),   2);
    btn_raw = 1'b0;
    ticks(8);

    // 300 presses: count saturates at 255
    pulse_seen = 0;
    for (int p = 0; p < 300; p++) begin
      btn_raw = 1'b1;
      ticks(8);
      btn_raw = 1'b0;
      ticks(8);
    end
    check("sat_pulses",  32'(pulse_seen),  300);
    check("sat_count",   32'(req_count),   255);
    check("sat_pending", 32'(req_pending), 1);

    // Reset during DEBOUNCE_HIGH with the button held
    pulse_seen = 0;
    btn_raw = 1'b1;
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    check("async_level",   32'(btn_level),   0);
    check("async_pulse",   32'(btn_pulse),   0);
    check("async_pending", 32'(req_pending), 0);
    check("async_count",   32'(req_count),   0);
    ticks(2);
    rst = 1'b0;
    ticks(5);
    check("rel_level_e5", 32'(btn_level), 0);
    tick();
    check("rel_level_e6", 32'(btn_level), 1);
    check("rel_pulse_e6", 32'(btn_pulse), 1);
    tick();
    check("rel_count",   32'(req_count),   1);
    check("rel_pending", 32'(req_pending), 1);
    ticks(10);
    check("rel_pulses", 32'(pulse_seen), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ped_request_conditioner.md
PED_REQUEST_CONDITIONER -- requirements
Module: ped_request_conditioner

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 125_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter DEBOUNCE_MS, default 20, meaning the debounce window in ms.
REQ-003 The block SHALL define a derived constant DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS; elaboration SHALL fail if DB_CYCLES < 2.
REQ-004 Port: clk  input  1  system clock; the only clock.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: btn_raw  input  1  raw pedestrian push-button, asynchronous to clk, 1 = pressed.
REQ-007 Port: ack  input  1  single-cycle strobe from the traffic-light controller meaning the request has been served (RED phase entered).
REQ-008 Port: btn_level  output  1  debounced button level.
REQ-009 Port: btn_pulse  output  1  one-cycle strobe on each debounced press (0->1 of btn_level).
REQ-010 Port: req_pending  output  1  latched pedestrian request awaiting service.
REQ-011 Port: req_count  output  8  number of debounced presses since reset, saturating.

Function
REQ-012 btn_raw SHALL pass through a two-flop synchronizer; btn_sync is the second flop output, and no other logic SHALL sample btn_raw.
REQ-013 The debounce FSM SHALL have the states STABLE_LOW, DEBOUNCE_HIGH, STABLE_HIGH and DEBOUNCE_LOW.
REQ-014 STABLE_LOW SHALL go to DEBOUNCE_HIGH when btn_sync=1, with the counter cleared to 0.
REQ-015 DEBOUNCE_HIGH SHALL increment the counter each cycle btn_sync=1; on btn_sync=0 it SHALL return to STABLE_LOW with the counter cleared, and when the counter equals DB_CYCLES-1 with btn_sync=1 it SHALL go to STABLE_HIGH.
REQ-016 STABLE_HIGH and DEBOUNCE_LOW SHALL mirror REQ-014 and REQ-015 with polarity inverted.
REQ-017 btn_level SHALL be registered and SHALL equal 1 exactly in STABLE_HIGH and DEBOUNCE_LOW.
REQ-018 btn_pulse SHALL be registered and SHALL be high for exactly the one cycle in which btn_level first reads 1 after a 0.
REQ-019 Latency: for a clean step on btn_raw, btn_level SHALL change on the (DB_CYCLES+2)th rising clk edge after the step; the debounce counter width SHALL be $clog2(DB_CYCLES).
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles SHALL NOT change btn_level or produce btn_pulse.
REQ-021 req_pending SHALL be set on the edge after btn_pulse and cleared on the edge after ack.
REQ-022 If btn_pulse and ack are high in the same cycle, req_pending SHALL be 1 afterwards (the new request wins).
REQ-023 ack while req_pending=0 SHALL have no effect.
REQ-024 A press while req_pending=1 SHALL keep it at 1 and SHALL still increment req_count.
REQ-025 req_count SHALL increment by 1 on each btn_pulse and SHALL saturate at 255 (no wrap).
REQ-026 A held button SHALL generate exactly one btn_pulse regardless of hold time.

Reset
REQ-027 rst=1 SHALL immediately and asynchronously force the synchronizer flops to 0, the FSM to STABLE_LOW, the counter to 0, btn_level=0, btn_pulse=0, req_pending=0 and req_count=0.
REQ-028 If rst is asserted mid-debounce or during a hold, the partial count SHALL be discarded; a button still held at deassertion SHALL be debounced afresh and produce one btn_pulse.
REQ-029 Reset deassertion SHALL be synchronized externally; the block SHALL NOT contain a reset synchronizer.

Structure
REQ-030 The debounce state enum typedef and the 8-bit count width constant SHALL live in the shared package ped_cond_pkg.
REQ-031 The two-flop synchronizer SHALL be a separate sub-module sync_2ff with an asynchronous, active-high reset.
REQ-032 FSM, counter, pending latch and req_count SHALL reside in ped_request_conditioner, with no other sub-modules.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4, so DB_CYCLES=4)
REQ-033 The bench SHALL cover: btn_raw 0->1, held for 20 cycles -> btn_level rises on the 6th edge; btn_pulse is high for 1 cycle; req_pending=1 from the next edge; req_count=1.
REQ-034 The bench SHALL cover: btn_raw high for 3 cycles, then low -> btn_level, btn_pulse and req_pending stay 0; req_count stays 0.
REQ-035 The bench SHALL cover: pending request followed by a 1-cycle ack -> req_pending=0 on the next edge; ack repeated with nothing pending -> no change.
REQ-036 The bench SHALL cover: btn_pulse coincident with ack -> req_pending stays 1 and req_count increments.
REQ-037 The bench SHALL cover: 300 clean presses -> req_count=255 with no wrap, and exactly 300 btn_pulse strobes counted by the bench.
REQ-038 The bench SHALL cover: rst asserted during DEBOUNCE_HIGH with btn_raw held, then released -> all outputs are 0 asynchronously; btn_level rises 6 edges after deassertion, with one btn_pulse.
